// File: rtl/shift_sequencer.sv
// Operand-2 shifter: one bit position per clock for LSL/LSR/ASR/ROR/RRX with ARM carry-out.
// Latency steps+1 cycles (1..34); start is ignored while busy, flush aborts to IDLE without done.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       shift_type,
  input  logic             amount_is_reg,
  input  logic [7:0]       amount,
  input  logic [WIDTH-1:0] operand_in,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam logic [CNT_W-1:0] STEPS_32 = CNT_W'(32);
  localparam logic [CNT_W-1:0] STEPS_33 = CNT_W'(33);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, steps;
  logic [1:0]       typ;
  logic             rrx, rrx_nxt, cin_q;
  logic [WIDTH-1:0] r;
  logic             c;

  // Step count from the raw amount; over-long register shifts run 33 steps so the
  // carry naturally falls to zero for LSL/LSR.
  always_comb begin
    steps   = '0;
    rrx_nxt = 1'b0;
    if (!amount_is_reg) begin
      if (amount[4:0] == 5'd0) begin
        case (shift_type)
          SH_LSL:  steps = '0;
          SH_ROR: begin
            steps   = CNT_W'(1);
            rrx_nxt = 1'b1;
          end
          default: steps = STEPS_32;
        endcase
      end else begin
        steps = CNT_W'(amount[4:0]);
      end
    end else if (amount != 8'd0) begin
      case (shift_type)
        SH_LSL, SH_LSR: steps = (amount > 8'd33) ? STEPS_33 : CNT_W'(amount);
        SH_ASR:         steps = (amount > 8'd32) ? STEPS_32 : CNT_W'(amount);
        default:        steps = (amount[4:0] == 5'd0) ? STEPS_32 : CNT_W'(amount[4:0]);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (steps == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r     <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      typ   <= SH_LSL;
      rrx   <= 1'b0;
      cin_q <= 1'b0;
    end else if (!flush) begin
      if (state == IDLE && start) begin
        r     <= operand_in;
        c     <= carry_in;
        cnt   <= steps;
        typ   <= shift_type;
        rrx   <= rrx_nxt;
        cin_q <= carry_in;
      end else if (state == SHIFT) begin
        cnt <= cnt - CNT_W'(1);
        if (rrx) begin
          c <= r[0];
          r <= {cin_q, r[WIDTH-1:1]};
        end else begin
          case (typ)
            SH_LSL: begin
              c <= r[WIDTH-1];
              r <= {r[WIDTH-2:0], 1'b0};
            end
            SH_LSR: begin
              c <= r[0];
              r <= {1'b0, r[WIDTH-1:1]};
            end
            SH_ASR: begin
              c <= r[0];
              r <= {r[WIDTH-1], r[WIDTH-1:1]};
            end
            default: begin
              c <= r[0];
              r <= {r[0], r[WIDTH-1:1]};
            end
          endcase
        end
      end
    end
  end

  // Gating done with flush keeps an abort in the DONE cycle from signalling completion.
  assign busy      = (state != IDLE);
  assign done      = (state == DONE) && !flush;
  assign result    = r;
  assign carry_out = c;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: vector table plus handshake, flush and reset sequences.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  shift_type = 2'b00;
  logic        amount_is_reg = 1'b0;
  logic [7:0]  amount = 8'd0;
  logic [31:0] operand_in = 32'd0;
  logic        carry_in = 1'b0;
  logic        busy, done, carry_out;
  logic [31:0] result;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush),
    .shift_type(shift_type), .amount_is_reg(amount_is_reg), .amount(amount),
    .operand_in(operand_in), .carry_in(carry_in),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out)
  );

  typedef struct {
    string       name;
    logic [1:0]  typ;
    logic        is_reg;
    logic [7:0]  amt;
    logic [31:0] op;
    logic        cin;
    logic [31:0] exp_r;
    logic        exp_c;
    int          exp_lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Start one op and wait for done; returns latency counted from the start edge.
  task automatic run_op(input logic [1:0] typ, input logic is_reg, input logic [7:0] amt,
                        input logic [31:0] op, input logic cin, output int lat, output logic busy_first);
    @(negedge clk);
    shift_type = typ; amount_is_reg = is_reg; amount = amt; operand_in = op; carry_in = cin;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    operand_in = ~op;
    carry_in = ~cin;
    busy_first = busy;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int   lat;
    logic bf;
    int   dones;

    vecs[0]  = '{"imm_lsl4",    2'b00, 1'b0, 8'hE4, 32'h8000_000F, 1'b0, 32'h0000_00F0, 1'b0, 5};
    vecs[1]  = '{"imm_lsr32",   2'b01, 1'b0, 8'h00, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 33};
    vecs[2]  = '{"imm_asr32",   2'b10, 1'b0, 8'h00, 32'h8000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 33};
    vecs[3]  = '{"imm_rrx",     2'b11, 1'b0, 8'h00, 32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1, 2};
    vecs[4]  = '{"reg_lsl32",   2'b00, 1'b1, 8'd32, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 33};
    vecs[5]  = '{"reg_lsl40",   2'b00, 1'b1, 8'd40, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 34};
    vecs[6]  = '{"reg_ror64",   2'b11, 1'b1, 8'd64, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 33};
    vecs[7]  = '{"reg_lsr0",    2'b01, 1'b1, 8'd0,  32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1};
    vecs[8]  = '{"reg_asr0",    2'b10, 1'b1, 8'd0,  32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1};
    vecs[9]  = '{"reg_asr200",  2'b10, 1'b1, 8'd200, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 33};
    vecs[10] = '{"reg_lsr33",   2'b01, 1'b1, 8'd33, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0, 34};
    vecs[11] = '{"imm_ror8",    2'b11, 1'b0, 8'd8,  32'h0000_00AB, 1'b0, 32'hAB00_0000, 1'b1, 9};
    vecs[12] = '{"imm_lsr1",    2'b01, 1'b0, 8'd1,  32'h0000_0003, 1'b0, 32'h0000_0001, 1'b1, 2};
    vecs[13] = '{"reg_ror36",   2'b11, 1'b1, 8'd36, 32'h0000_001F, 1'b0, 32'hF000_0001, 1'b1, 5};
    vecs[14] = '{"imm_lsl0",    2'b00, 1'b0, 8'd0,  32'h0000_0055, 1'b1, 32'h0000_0055, 1'b1, 1};

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].typ, vecs[i].is_reg, vecs[i].amt, vecs[i].op, vecs[i].cin, lat, bf);
      chk({vecs[i].name, "_result"}, result, vecs[i].exp_r);
      chk({vecs[i].name, "_carry"}, 32'(carry_out), 32'(vecs[i].exp_c));
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      chk({vecs[i].name, "_busy"}, 32'(bf), 32'd1);
      @(posedge clk); #1;
      chk({vecs[i].name, "_idle"}, 32'(busy), 32'd0);
    end

    // Handshake: start held through SHIFT and the DONE cycle is ignored.
    @(negedge clk);
    shift_type = 2'b00; amount_is_reg = 1'b0; amount = 8'd3; operand_in = 32'h1; carry_in = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    operand_in = 32'hFFFF;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (done) dones++;
      chk($sformatf("hs_busy_%0d", k), 32'(busy), (k <= 3) ? 32'd1 : 32'd0);
      if (k == 4) start = 1'b0;
    end
    chk("hs_done_count", 32'(dones), 32'd1);
    chk("hs_result", result, 32'h8);

    // Flush after three steps of a 20-step shift; new start accepted right away.
    @(negedge clk);
    shift_type = 2'b00; amount_is_reg = 1'b0; amount = 8'd20; operand_in = 32'h1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    if (done) dones++;
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_result_held", result, 32'h8);
    flush = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("fl_no_done", 32'(dones), 32'd0);
    run_op(2'b01, 1'b0, 8'd1, 32'h4, 1'b1, lat, bf);
    chk("fl_restart_result", result, 32'h2);
    chk("fl_restart_carry", 32'(carry_out), 32'd0);
    chk("fl_restart_lat", 32'(lat), 32'd2);

    // Asynchronous reset mid-shift.
    @(negedge clk);
    shift_type = 2'b10; amount_is_reg = 1'b0; amount = 8'd0; operand_in = 32'h8000_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_result", result, 32'd0);
    chk("ar_carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("ar_no_done", 32'(dones), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle sequencer for the operand-2 shift path. It executes ARM shift operations (LSL, LSR, ASR, ROR, RRX) one bit position per clock.
- Amount comes from either the instruction immediate or the low byte of Rs (register-specified shift).
- Sits between the control unit and the ALU operand-2 input.
- Provides start/busy/done handshake and full ARM shifter carry-out semantics, including register-shift amounts of 32 and above.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.
- CNT_W, 6, step counter width; must hold 0..33.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous reset, active-low.
- start  input  1  request; sampled only in IDLE.
- flush  input  1  synchronous abort; returns to IDLE and suppresses done.
- shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- amount_is_reg  input  1  0: immediate amount (amount[4:0]); 1: register amount (amount[7:0]).
- amount  input  8  shift amount.
- operand_in  input  32  Rm value.
- carry_in  input  1  current CPSR C.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; result and carry_out valid.
- result  output  32  shifted operand.
- carry_out  output  1  shifter carry-out.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, busy=0, done=0, result=0, carry_out=0, counter=0.
- States:
  - IDLE: on start, latch operand_in into the result register and carry_in into the carry register. Latch shift_type, compute steps, enter SHIFT if steps>0, else DONE.
  - SHIFT: one step per cycle, decrement counter; after the step that makes counter 0, enter DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Steps computation, immediate (amt = amount[4:0]):
  - LSL: amt.
  - LSR: amt==0 ? 32 : amt.
  - ASR: amt==0 ? 32 : amt.
  - ROR: amt==0 ? RRX (1 step) : amt.
- Steps computation, register (a = amount[7:0]):
  - a==0 gives 0 steps for all types.
  - LSL/LSR: min(a, 33).
  - ASR: min(a, 32).
  - ROR: a[4:0]==0 ? 32 : a[4:0].
- Per step (r = result register, c = carry register):
  - LSL: c=r[31], r={r[30:0],0}.
  - LSR: c=r[0], r={0,r[31:1]}.
  - ASR: c=r[0], r={r[31],r[31:1]}.
  - ROR: c=r[0], r={r[0],r[31:1]}.
  - RRX: c=r[0], r={carry_in latched, r[31:1]}.
- These rules yield the ARM results without special-casing:
  - Shift by 32 gives C = last bit out.
  - Shift by 33 or more gives r=0, C=0 for LSL/LSR.
  - ROR by a multiple of 32 gives r=Rm, C=Rm[31].
  - Zero steps gives r=Rm, C=carry_in.
- Latency: start sampled at edge E0; done is high in the cycle after edge E0+steps. Total is steps+1 cycles, minimum 1 and maximum 34.
- result and carry_out hold their values after done until the next accepted start. Each SHIFT step updates them, so intermediate values are visible; consumers use them only on done.
- start while busy: ignored, no queuing.
- start and done in the same cycle: start is ignored, because the state is DONE, not IDLE.
- flush, any state: next state IDLE, done=0; result and carry_out keep their current values. flush has priority over start in IDLE.
- reset_n asserted mid-operation: immediate return to reset values; no done is produced.
- Input changes after the start edge have no effect; all inputs are latched.

Test Plan:
- Immediate LSL #4, operand_in=0x8000_000F, carry_in=0 -> done after 5 cycles, result=0x0000_00F0, carry_out=0.
- Immediate LSR #0 (LSR #32), operand_in=0x8000_0000 -> 33-cycle latency, result=0x0000_0000, carry_out=1. Immediate ASR #0, operand_in=0x8000_0001 -> result=0xFFFF_FFFF, carry_out=1.
- Immediate ROR #0 (RRX), operand_in=0x0000_0003, carry_in=1 -> done after 2 cycles, result=0x8000_0001, carry_out=1.
- Register cases:
  - LSL a=32, operand_in=0x0000_0001 -> result=0, carry_out=1.
  - LSL a=40 -> result=0, carry_out=0, latency 34.
  - ROR a=64, operand_in=0x8000_0000 -> result=0x8000_0000, carry_out=1.
  - Any type with a=0, carry_in=1 -> result=operand_in, carry_out=1, latency 1.
- Handshake: start pulsed again during SHIFT and in the DONE cycle -> ignored; exactly one done per accepted start; busy=1 from E0+1 through the done cycle.
- Abort and reset:
  - flush at cycle 3 of a 20-step shift -> IDLE next cycle, no done pulse; a new start is accepted immediately.
  - reset_n=0 mid-shift -> busy=0, done=0, result=0, carry_out=0 without waiting for a clock edge.
